// File: rtl/sound_pkg.sv
// Shared constants and types for the main/sound CPU mailbox.
package sound_pkg;

  localparam int unsigned DefaultWidth  = 8;
  localparam int unsigned DefaultDepth  = 4;
  // Wide enough for the occupancy of the largest allowed FIFO (64 entries).
  localparam int unsigned MaxCountWidth = 7;

  typedef struct packed {
    logic [MaxCountWidth-1:0] count;
    logic                     rdy;
    logic                     ovf;
  } mbox_status_t;

endpackage

// File: rtl/sound_fifo.sv
// One direction of the mailbox: small FIFO with held output, sticky overflow and flush.
module sound_fifo
  import sound_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // A one-entry FIFO still needs a legal vector; its pointer simply never leaves 0.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;

  logic full, empty, do_push, do_pop, ovf_set;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Decide which requests take effect this cycle; flush wins over both.
  always_comb begin
    do_pop  = rd & ~empty & ~flush;
    // A pop frees the slot on the same edge, so a full FIFO still accepts the push.
    do_push = wr & (~full | (rd & ~empty)) & ~flush;
    ovf_set = wr & full & ~rd & ~flush;
  end

  // Next-state for pointers, occupancy, held output and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        hold_d   = mem_q[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Set has priority over clear when both happen in one cycle.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Head shown live while non-empty, otherwise the last popped value.
  always_comb begin
    dout  = empty ? hold_q : mem_q[rd_ptr_q];
    rdy   = ~empty;
    count = count_q;
    ovf   = ovf_q;
  end

endmodule

// File: rtl/sound_mailbox.sv
// Bidirectional command/reply mailbox between the main CPU and the sound CPU.
module sound_mailbox
  import sound_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             m2s_wr,
  input  logic [WIDTH-1:0] m2s_din,
  input  logic             s_rd,
  output logic [WIDTH-1:0] s_dout,
  output logic             s_rdy,
  output logic             s_irq_n,
  input  logic             s2m_wr,
  input  logic [WIDTH-1:0] s2m_din,
  input  logic             m_rd,
  output logic [WIDTH-1:0] m_dout,
  output logic             m_rdy,
  output logic [CW-1:0]    m2s_count,
  output logic [CW-1:0]    s2m_count,
  output logic             m2s_ovf,
  output logic             s2m_ovf,
  input  logic             ovf_clr,
  input  logic             m2s_flush,
  input  logic             s2m_flush
);

  // Main CPU to sound CPU commands.
  sound_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_m2s (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr      (m2s_wr),
    .din     (m2s_din),
    .rd      (s_rd),
    .flush   (m2s_flush),
    .ovf_clr (ovf_clr),
    .dout    (s_dout),
    .rdy     (s_rdy),
    .count   (m2s_count),
    .ovf     (m2s_ovf)
  );

  // Sound CPU to main CPU replies.
  sound_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_s2m (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr      (s2m_wr),
    .din     (s2m_din),
    .rd      (m_rd),
    .flush   (s2m_flush),
    .ovf_clr (ovf_clr),
    .dout    (m_dout),
    .rdy     (m_rdy),
    .count   (s2m_count),
    .ovf     (s2m_ovf)
  );

  // Sound CPU interrupt stays asserted while a command is waiting.
  always_comb begin
    s_irq_n = ~s_rdy;
  end

endmodule

// File: tb/tb_sound_mailbox.sv
// Scoreboard bench for sound_mailbox (WIDTH=8, DEPTH=4).
module tb_sound_mailbox;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          m2s_wr = 1'b0, s_rd = 1'b0, s2m_wr = 1'b0, m_rd = 1'b0;
  logic [W-1:0]  m2s_din = '0, s2m_din = '0;
  logic          ovf_clr = 1'b0, m2s_flush = 1'b0, s2m_flush = 1'b0;
  logic [W-1:0]  s_dout, m_dout;
  logic          s_rdy, s_irq_n, m_rdy, m2s_ovf, s2m_ovf;
  logic [CW-1:0] m2s_count, s2m_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_m2s[$];
  logic [W-1:0] exp_s2m[$];

  sound_mailbox #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .m2s_wr    (m2s_wr),
    .m2s_din   (m2s_din),
    .s_rd      (s_rd),
    .s_dout    (s_dout),
    .s_rdy     (s_rdy),
    .s_irq_n   (s_irq_n),
    .s2m_wr    (s2m_wr),
    .s2m_din   (s2m_din),
    .m_rd      (m_rd),
    .m_dout    (m_dout),
    .m_rdy     (m_rdy),
    .m2s_count (m2s_count),
    .s2m_count (s2m_count),
    .m2s_ovf   (m2s_ovf),
    .s2m_ovf   (s2m_ovf),
    .ovf_clr   (ovf_clr),
    .m2s_flush (m2s_flush),
    .s2m_flush (s2m_flush)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; monitor samples on the falling edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_m2s(input logic [W-1:0] v, input bit expect_kept);
    m2s_wr = 1'b1; m2s_din = v;
    if (expect_kept) exp_m2s.push_back(v);
    step();
    m2s_wr = 1'b0;
  endtask

  task automatic push_s2m(input logic [W-1:0] v, input bit expect_kept);
    s2m_wr = 1'b1; s2m_din = v;
    if (expect_kept) exp_s2m.push_back(v);
    step();
    s2m_wr = 1'b0;
  endtask

  task automatic pop_m2s();
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
  endtask

  task automatic pop_s2m();
    m_rd = 1'b1;
    step();
    m_rd = 1'b0;
  endtask

  // Monitor: every accepted pop must present the scoreboard head on dout.
  always @(negedge clk_sys) begin
    if (reset_n && s_rd && s_rdy) begin
      if (exp_m2s.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL m2s_pop: got 0x%0h expected nothing queued", s_dout);
      end else begin
        chk("m2s_pop", 32'(s_dout), 32'(exp_m2s.pop_front()));
      end
    end
    if (reset_n && m_rd && m_rdy) begin
      if (exp_s2m.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL s2m_pop: got 0x%0h expected nothing queued", m_dout);
      end else begin
        chk("s2m_pop", 32'(m_dout), 32'(exp_s2m.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_s_rdy", 32'(s_rdy), 0);
    chk("rst_s_irq_n", 32'(s_irq_n), 1);
    chk("rst_m_rdy", 32'(m_rdy), 0);
    chk("rst_counts", {m2s_count, s2m_count}, 0);
    chk("rst_ovf", {m2s_ovf, s2m_ovf}, 0);
    chk("rst_douts", {s_dout, m_dout}, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();

    // Basic m2s traffic
    push_m2s(8'h11, 1'b1);
    chk("m2s_rdy_latency", 32'(s_rdy), 1);
    chk("m2s_irq_low", 32'(s_irq_n), 0);
    push_m2s(8'h22, 1'b1);
    push_m2s(8'h33, 1'b1);
    chk("m2s_count3", 32'(m2s_count), 3);
    for (int i = 0; i < 3; i++) pop_m2s();
    chk("m2s_rdy_empty", 32'(s_rdy), 0);
    chk("m2s_irq_idle", 32'(s_irq_n), 1);
    chk("m2s_hold_33", 32'(s_dout), 32'h33);
    pop_m2s();  // empty pop ignored
    chk("m2s_empty_pop_count", 32'(m2s_count), 0);

    // s2m overflow
    for (int i = 0; i < 5; i++) push_s2m(8'hA1 + 8'(i), i < 4);
    chk("s2m_count_full", 32'(s2m_count), 4);
    chk("s2m_ovf_set", 32'(s2m_ovf), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("s2m_ovf_clr", 32'(s2m_ovf), 0);
    for (int i = 0; i < 4; i++) pop_s2m();
    chk("s2m_drained", 32'(m_rdy), 0);

    // Push and pop together on a full FIFO
    for (int i = 1; i <= 4; i++) push_m2s(8'(i), 1'b1);
    m2s_wr = 1'b1; m2s_din = 8'hAA; s_rd = 1'b1;
    exp_m2s.push_back(8'hAA);
    step();
    m2s_wr = 1'b0; s_rd = 1'b0;
    chk("full_pp_count", 32'(m2s_count), 4);
    chk("full_pp_ovf", 32'(m2s_ovf), 0);
    for (int i = 0; i < 4; i++) pop_m2s();

    // Push and pop together on an empty FIFO
    m2s_wr = 1'b1; m2s_din = 8'h5C; s_rd = 1'b1;
    exp_m2s.push_back(8'h5C);
    #3;
    chk("empty_pp_hold", 32'(s_dout), 32'hAA);
    step();
    m2s_wr = 1'b0; s_rd = 1'b0;
    chk("empty_pp_count", 32'(m2s_count), 1);
    pop_m2s();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push_s2m(8'h31 + 8'(i), 1'b0);
    chk("pre_rst_count", 32'(s2m_count), 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_m_rdy", 32'(m_rdy), 0);
    chk("async_rst_counts", {m2s_count, s2m_count}, 0);
    chk("async_rst_hold", {s_dout, m_dout}, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();
    push_s2m(8'h77, 1'b1);
    chk("post_rst_count", 32'(s2m_count), 1);
    pop_s2m();

    // Flush with a simultaneous push, ovf and held dout untouched
    push_m2s(8'h42, 1'b1);
    pop_m2s();
    for (int i = 0; i < 4; i++) push_m2s(8'hC0 + 8'(i), 1'b1);
    push_m2s(8'hEE, 1'b0);
    chk("m2s_ovf_set", 32'(m2s_ovf), 1);
    m2s_wr = 1'b1; m2s_din = 8'hEF; ovf_clr = 1'b1;
    step();
    m2s_wr = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_beats_clr", 32'(m2s_ovf), 1);
    m2s_flush = 1'b1; m2s_wr = 1'b1; m2s_din = 8'h99;
    exp_m2s.delete();
    step();
    m2s_flush = 1'b0; m2s_wr = 1'b0;
    chk("flush_count", 32'(m2s_count), 0);
    chk("flush_rdy", 32'(s_rdy), 0);
    chk("flush_ovf_kept", 32'(m2s_ovf), 1);
    chk("flush_hold", 32'(s_dout), 32'h42);
    push_m2s(8'h88, 1'b1);
    pop_m2s();

    step();
    chk("m2s_sb_empty", 32'(exp_m2s.size()), 0);
    chk("s2m_sb_empty", 32'(exp_s2m.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
